// File: rtl/aes_pkg.sv
// Shared AES decryption datapath types: block/byte typedefs, the stage FSM enum
// and the inverse S-box constant table.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W   = 128;
    localparam int unsigned AES_BYTE_W    = 8;
    localparam int unsigned AES_NUM_BYTES = AES_BLOCK_W / AES_BYTE_W;

    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;
    // Byte k occupies bits [8k +: 8]; byte 0 is the leftmost byte of a hex literal.
    typedef logic [0:AES_BLOCK_W-1] aes_block_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } ibs_state_e;

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup for one byte.
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t din,
    output aes_byte_t dout_c
);

    assign dout_c = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes: BYTES_PER_CYCLE bytes per falling edge, valid/ready on both sides.
// Define INV_SBOX_REG_EN to register the S-box outputs (one extra edge of latency).
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_block_t data_in,
    output aes_block_t data_out,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int unsigned N_GRP = AES_NUM_BYTES / BYTES_PER_CYCLE;
    localparam int unsigned CNT_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(N_GRP - 1);

    ibs_state_e       state_q, state_d;
    logic [CNT_W-1:0] g_q, g_d;
    aes_block_t       work_q, work_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    aes_byte_t sbox_in  [BYTES_PER_CYCLE];
    aes_byte_t sbox_out [BYTES_PER_CYCLE];

`ifdef INV_SBOX_REG_EN
    aes_byte_t        sub_q [BYTES_PER_CYCLE];
    aes_byte_t        sub_d [BYTES_PER_CYCLE];
    logic [CNT_W-1:0] wr_g_q, wr_g_d;
    logic             pend_q, pend_d;
    logic             look_done_q, look_done_d;
`endif

    // Bit offset of byte i within group g.
    function automatic logic [6:0] bit_ofs(input logic [CNT_W-1:0] g, input int unsigned i);
        return 7'((32'(g) * BYTES_PER_CYCLE + i) * AES_BYTE_W);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
            sbox_in[i] = work_q[bit_ofs(g_q, i) +: AES_BYTE_W];
        end
    end

    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .din    (sbox_in[gi]),
            .dout_c (sbox_out[gi])
        );
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        work_d  = work_q;
`ifdef INV_SBOX_REG_EN
        sub_d       = sub_q;
        wr_g_d      = wr_g_q;
        pend_d      = 1'b0;
        look_done_d = look_done_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = data_in;
                    g_d     = '0;
                    state_d = ST_BUSY;
`ifdef INV_SBOX_REG_EN
                    look_done_d = 1'b0;
`endif
                end
            end
            ST_BUSY: begin
`ifdef INV_SBOX_REG_EN
                // Write-back of the previous lookup overlaps the lookup of the next group.
                if (pend_q) begin
                    for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
                        work_d[bit_ofs(wr_g_q, i) +: AES_BYTE_W] = sub_q[i];
                    end
                    if (wr_g_q == LAST_GRP) begin
                        state_d = ST_DONE;
                    end
                end
                if (!look_done_q) begin
                    sub_d  = sbox_out;
                    wr_g_d = g_q;
                    pend_d = 1'b1;
                    if (g_q == LAST_GRP) begin
                        look_done_d = 1'b1;
                    end else begin
                        g_d = g_q + CNT_W'(1);
                    end
                end
`else
                for (int unsigned i = 0; i < BYTES_PER_CYCLE; i++) begin
                    work_d[bit_ofs(g_q, i) +: AES_BYTE_W] = sbox_out[i];
                end
                if (g_q == LAST_GRP) begin
                    state_d = ST_DONE;
                end else begin
                    g_d = g_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef INV_SBOX_REG_EN
            sub_q       <= '{default: '0};
            wr_g_q      <= '0;
            pend_q      <= 1'b0;
            look_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            work_q      <= work_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef INV_SBOX_REG_EN
            sub_q       <= sub_d;
            wr_g_q      <= wr_g_d;
            pend_q      <= pend_d;
            look_done_q <= look_done_d;
`endif
        end
    end

    assign data_out  = work_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

endmodule
